darkseq: RTL
============

# darkseq

Instruction sequencer sitting directly upstream of the ALU/branch/register-file stage. Fetches each instruction over an instruction-memory handshake and presents `pc`/`inst`. Runs the ALU enable/valid handshake, performs the data-memory access for loads and stores, returns load data through the writeback handshake, then advances `pc` from the stage's `nxpc`. Strictly one instruction in flight; no pipelining.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `res` in 1: reset, asynchronous, active-high.
- `halt` in 1: when high, no new fetch starts.
- `imem_req` out 1 / `imem_addr` out 32 / `imem_ack` in 1 / `imem_rdata` in 32: instruction fetch handshake.
- `dmem_req` out 1 / `dmem_we` out 1 / `dmem_be` out 4 / `dmem_addr` out 32 / `dmem_wdata` out 32 / `dmem_ack` in 1 / `dmem_rdata` in 32: data access handshake.
- `pc` out 32, `inst` out 32: current instruction, held stable from fetch to retire.
- `en_al` out 1 / `valid_al` in 1 / `addr_al` in 32 / `data_al` in 32: execute handshake, effective address and lane-aligned store data.
- `en_wb` out 1 / `valid_wb` in 1 / `data_wb` out 32: writeback handshake and raw load word.
- `nxpc` in 32: next PC from the execute stage.
- `instret` out 32: retired-instruction counter.
- `fault` out 1: sticky misaligned-PC fault.

## Operation
- Opcode is decoded from `inst[6:0]`:
  - LCC = 0000011
  - SCC = 0100011
  - BCC = 1100011
  - Everything else is a "register" class instruction, including unimplemented opcodes.
- States: IDLE, IFETCH, EXEC, EWAIT, MEM, WBACK, WWAIT, NEXT, FAULT.
- IDLE: leave to IFETCH when `halt`=0.
- IFETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`: `inst`<=`imem_rdata`, go to EXEC.
- EXEC: `en_al`=1 for exactly one cycle, then EWAIT.
- EWAIT: wait for `valid_al`, then branch on class:
  - LCC or SCC: MEM.
  - BCC: NEXT.
  - Otherwise: WBACK.
- MEM:
  - `dmem_req`=1 and `dmem_addr`={`addr_al`[31:2],2'b00}.
  - Store: `dmem_we`=1 and `dmem_wdata`=`data_al`.
  - Load: `dmem_we`=0 and `dmem_be`=4'hF.
  - Store byte enables come from `inst[14:12]` and `addr_al[1:0]`:
    - fct3=0: `dmem_be` = 4'b0001<<`addr_al[1:0]`.
    - fct3=1: `addr_al[1]` ? 4'b1100 : 4'b0011.
    - Otherwise: 4'hF.
  - On `dmem_ack`: a load captures `data_wb`<=`dmem_rdata` and goes to WBACK; a store goes to NEXT.
- WBACK: `en_wb`=1 for one cycle, then WWAIT. `data_wb` stays stable until the next load capture.
- WWAIT: wait for `valid_wb`, then NEXT.
- NEXT:
  - If `nxpc[1:0]`≠0: `fault`<=1, go to FAULT; `pc` and `instret` are unchanged.
  - Otherwise: `pc`<=`nxpc`, `instret`<=`instret`+1, then go to IFETCH if `halt`=0, else IDLE.
- FAULT: terminal. No requests or enables are issued until reset.
- `instret` is 32-bit modulo: 32'hFFFF_FFFF+1 = 0.
- Acks and valids arriving in states that do not wait for them are ignored.

## Timing
- Reset values, applied immediately on `res` rise:
  - state IDLE, `pc`=`RESET_PC`, `inst`=0, `data_wb`=0, `instret`=0, `fault`=0.
  - `imem_req`, `dmem_req`, `dmem_we`, `en_al`, `en_wb` = 0; `dmem_be`=0; `imem_addr`=`RESET_PC`; `dmem_addr`=0, `dmem_wdata`=0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Request signals hold, with stable address and data, until the cycle their ack is sampled high. The ack may come in the same cycle the request first asserts.
- `en_al` and `en_wb` are single-cycle pulses, one per instruction.
- `addr_al`/`data_al` are used only in MEM; the execute stage holds them until the next `en_al`.
- Minimum cycles per instruction, with zero-wait acks and valid one cycle after enable:
  - Register class: 6 (IFETCH, EXEC, EWAIT, WBACK, WWAIT, NEXT).
  - Load: 7.
  - Store: 5.
  - Branch: 4.
- Reset mid-transaction drops `imem_req`/`dmem_req` at once. A late ack after reset is ignored. The first fetch after `res` falls is issued on the next clock edge if `halt`=0.
- `halt` is sampled only in IDLE and NEXT. An instruction already in flight always completes.

## Test plan
- Reset, `RESET_PC`=0x100, zero-wait memory returning addi (0x00100093) -> `imem_addr`=0x100; `en_al` pulses one cycle; `en_wb` pulses one cycle; `pc`=`nxpc`=0x104 and `instret`=1 after 6 cycles.
- Store byte `sb` with `addr_al`=0x203 and `data_al`=0xAB000000 -> `dmem_addr`=0x200, `dmem_be`=4'b1000, `dmem_we`=1, `dmem_wdata`=0xAB000000; no `en_wb`; 5 cycles.
- Load word with `dmem_ack` delayed 3 cycles and `dmem_rdata`=0xDEADBEEF -> `dmem_req` and address held for all 4 request cycles; `data_wb`=0xDEADBEEF during `en_wb`; 10 cycles total.
- Branch with `nxpc`=0x302 -> `fault`=1, `pc` unchanged, `instret` unchanged, no further `imem_req` until reset.
- `halt` raised during a load -> the load completes and `instret` increments, then IDLE with no `imem_req`; dropping `halt` -> fetch on the next cycle.
- Preload `instret`=0xFFFFFFFF via a forced state, then retire one instruction -> `instret`=0. Assert `res` mid-IFETCH with `imem_ack` arriving the following cycle -> ack ignored and all outputs at their reset values.

Source files
------------

// File: rtl/darkseq_if.sv
// rtl/darkseq_if.sv - sequencer-side bundle: fetch, data, execute and writeback handshakes
interface darkseq_if;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        en_al;
  logic        valid_al;
  logic [31:0] addr_al;
  logic [31:0] data_al;
  logic        en_wb;
  logic        valid_wb;
  logic [31:0] data_wb;
  logic [31:0] nxpc;
  logic [31:0] instret;
  logic        fault;

  modport master (
    input  halt, imem_ack, imem_rdata, dmem_ack, dmem_rdata,
           valid_al, addr_al, data_al, valid_wb, nxpc,
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           pc, inst, en_al, en_wb, data_wb, instret, fault
  );

  modport slave (
    output halt, imem_ack, imem_rdata, dmem_ack, dmem_rdata,
           valid_al, addr_al, data_al, valid_wb, nxpc,
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           pc, inst, en_al, en_wb, data_wb, instret, fault
  );
endinterface

// File: rtl/darkseq.sv
// rtl/darkseq.sv - single-issue instruction sequencer: fetch, execute handshake, memory access, retire
module darkseq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     res,
  darkseq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_IFETCH, S_EXEC, S_EWAIT, S_MEM, S_WBACK, S_WWAIT, S_NEXT, S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, inst_q, data_wb_q, instret_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q;
  logic [3:0]  dmem_be_q, be_st;
  logic        fault_q;
  logic        is_ld, is_st, is_br, mis_pc;

  assign is_ld  = (inst_q[6:0] == 7'b0000011);
  assign is_st  = (inst_q[6:0] == 7'b0100011);
  assign is_br  = (inst_q[6:0] == 7'b1100011);
  assign mis_pc = (bus.nxpc[1:0] != 2'b00);

  always_comb begin
    be_st = 4'hF;
    if (inst_q[14:12] == 3'd0)
      be_st = 4'b0001 << bus.addr_al[1:0];
    else if (inst_q[14:12] == 3'd1)
      be_st = bus.addr_al[1] ? 4'b1100 : 4'b0011;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!bus.halt) state_d = S_IFETCH;
      S_IFETCH: if (bus.imem_ack) state_d = S_EXEC;
      S_EXEC:   state_d = S_EWAIT;
      S_EWAIT:
        if (bus.valid_al) begin
          if (is_ld || is_st) state_d = S_MEM;
          else if (is_br)     state_d = S_NEXT;
          else                state_d = S_WBACK;
        end
      S_MEM:    if (bus.dmem_ack) state_d = is_ld ? S_WBACK : S_NEXT;
      S_WBACK:  state_d = S_WWAIT;
      S_WWAIT:  if (bus.valid_wb) state_d = S_NEXT;
      S_NEXT: begin
        if (mis_pc)        state_d = S_FAULT;
        else if (bus.halt) state_d = S_IDLE;
        else               state_d = S_IFETCH;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Data-side request fields are latched on entry to MEM so they stay stable while waiting for ack.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      data_wb_q    <= '0;
      instret_q    <= '0;
      fault_q      <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
    end else begin
      if (state_q == S_IFETCH && bus.imem_ack)
        inst_q <= bus.imem_rdata;
      if (state_q == S_EWAIT && bus.valid_al && (is_ld || is_st)) begin
        dmem_addr_q  <= {bus.addr_al[31:2], 2'b00};
        dmem_wdata_q <= bus.data_al;
        dmem_be_q    <= is_ld ? 4'hF : be_st;
      end
      if (state_q == S_MEM && bus.dmem_ack && is_ld)
        data_wb_q <= bus.dmem_rdata;
      if (state_q == S_NEXT) begin
        if (mis_pc) begin
          fault_q <= 1'b1;
        end else begin
          pc_q      <= bus.nxpc;
          instret_q <= instret_q + 32'd1;
        end
      end
    end
  end

  assign bus.imem_req   = (state_q == S_IFETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == S_MEM);
  assign bus.dmem_we    = (state_q == S_MEM) && is_st;
  assign bus.dmem_be    = dmem_be_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.pc         = pc_q;
  assign bus.inst       = inst_q;
  assign bus.en_al      = (state_q == S_EXEC);
  assign bus.en_wb      = (state_q == S_WBACK);
  assign bus.data_wb    = data_wb_q;
  assign bus.instret    = instret_q;
  assign bus.fault      = fault_q;

endmodule
